systolic_pe_v2: RTL and testbench
=================================

Name: systolic_pe_v2

Overview:
- Parametrised next-generation systolic PE: out_psum = in_psum + in_data * active_weight.
- Adds double-buffered (shadow/active) weights with an explicit swap, so a new B tile loads while the current one streams.
- Adds a pipelined multiplier with parametrised latency, psum valid tracking, a weight forwarding chain down the column, and optional saturation.
- One instance per array cell: A data flows right, weights flow down, psums flow down.

Parameters:
- DATA_WIDTH, 8, signed width of A data and weights.
- PSUM_WIDTH, 32, signed partial-sum width; must be ≥ 2*DATA_WIDTH.
- MUL_LAT, 2, multiplier pipeline depth in cycles; must be ≥ 1.

Ports:
- s_clk  in  1  clock.
- s_rst_n  in  1  asynchronous, active-low reset.
- weight_valid  in  1  load weights into the shadow register this cycle.
- weights  in  DATA_WIDTH  shadow weight value.
- weight_swap  in  1  copy shadow into active.
- out_weight_valid  out  1  weight_valid delayed 1 cycle, for the PE below.
- out_weights  out  DATA_WIDTH  weights delayed 1 cycle; holds value when not valid.
- in_data_valid  in  1  A operand valid.
- in_raw_data  in  DATA_WIDTH  A operand.
- out_data_valid  out  1  in_data_valid delayed 1 cycle, for the PE to the right.
- out_raw_data  out  DATA_WIDTH  in_raw_data delayed 1 cycle; holds value when not valid.
- in_psum_valid  in  1  in_psum_data is meaningful.
- in_psum_data  in  PSUM_WIDTH  psum from the PE above.
- out_psum_valid  out  1  out_psum_data is new.
- out_psum_data  out  PSUM_WIDTH  accumulated result.
- psum_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset: every output, the shadow register, the active register and all pipeline valids go to 0 immediately (asynchronous). A reset mid-stream discards all in-flight products; no out_psum_valid is produced from pre-reset issues.
- Weights:
  - weight_valid=1 → shadow <= weights.
  - weight_swap=1 → active <= shadow; the new active weight is usable from the next cycle.
  - Both asserted in the same cycle → active takes the OLD shadow; shadow takes the new weights.
  - Every weight_valid is captured (no edge detect).
- Multiply:
  - Issue happens when in_data_valid=1; the operand is multiplied by the active value at the issue cycle.
  - A swap after issue does not affect in-flight products.
  - The product is a signed 2*DATA_WIDTH value, sign-extended to PSUM_WIDTH.
  - The product becomes valid MUL_LAT cycles after issue.
  - Full throughput: one issue per cycle, no bubbles.
- Accumulate:
  - When the product is valid (cycle t+MUL_LAT), sample in_psum_data, or use 0 if in_psum_valid=0 (top row ties in_psum_valid to 0).
  - At t+MUL_LAT+1: out_psum_valid=1 and out_psum_data=sum.
  - Total PE latency is MUL_LAT+1.
  - out_psum_data holds its value when out_psum_valid=0.
  - in_psum_valid without a valid product is ignored.
- Forwarding:
  - The data path and weight path are each a 1-cycle register, independent of MUL_LAT.
  - The integrator skews array inputs so in_psum meets the MUL_LAT alignment.
- Overflow:
  - Detect signed add overflow: operands share a sign and the result sign differs.
  - psum_ovf sets on overflow and clears only on reset.
  - Without the macro the sum wraps modulo 2^PSUM_WIDTH.

Optional Feature:
- SYSTOLIC_PE_SAT_EN defined: an overflowing sum clamps to the signed max (2^(PSUM_WIDTH-1)-1) or min (-2^(PSUM_WIDTH-1)); psum_ovf is set as above.
- Not defined: sums wrap; psum_ovf is still computed and sticky.

Decomposition:
- Shared package/header holds:
  - defaults for DATA_WIDTH / PSUM_WIDTH / MUL_LAT;
  - psum max/min constant functions of PSUM_WIDTH.
- One sub-module: systolic_mul_pipe.
  - Signed DATA_WIDTH x DATA_WIDTH multiplier with MUL_LAT stages and a valid shift chain.
  - Asynchronous active-low reset on valids only.

Test Plan (DATA_WIDTH=8, PSUM_WIDTH=32, MUL_LAT=2):
1. Reset → hold s_rst_n=0 with inputs toggling → every output 0; release → outputs stay 0 with no valids.
2. Basic MAC → weight_valid w=3, then swap, then data 5 at t; in_psum_valid=1, psum=10 at t+2 → out_psum_valid=1, out_psum_data=25 exactly at t+3; out_data_valid at t+1.
3. Signed / top row → w=-128, data=-128, in_psum_valid=0 → out_psum_data=16384. Also w=-1, data=127, psum=0 → -127.
4. Double buffer → active w=2, shadow w=7; stream data 1,1,1,1 back-to-back with swap in the same cycle as the 3rd issue → psums 2,2,2,7 (psum_in=0); weight_valid and swap together load the old shadow into active.
5. Overflow (PSUM_WIDTH=16) → in_psum=32767, w=1, data=1 → without macro: -32768 and psum_ovf=1; with SYSTOLIC_PE_SAT_EN: 32767 and psum_ovf=1; psum_ovf stays 1 until reset.
6. Reset mid-stream → issue 3 operands, assert s_rst_n=0 one cycle after the last issue, release → no out_psum_valid for those operands; next issue behaves as in scenario 2.

Source files
------------

// File: rtl/systolic_pe_v2_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pe_v2_pkg
//
// Purpose: shared defaults and helpers for the systolic processing element.
//   - DEF_DATA_WIDTH / DEF_PSUM_WIDTH / DEF_MUL_LAT : default parameter values
//   - psum_max() / psum_min() : signed saturation limits for a given psum width
//   - add_ovf()               : signed two-operand add overflow detector
//
// Optional feature macro used by the PE: SYSTOLIC_PE_SAT_EN (saturating psum).
// -----------------------------------------------------------------------------
package systolic_pe_v2_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PSUM_WIDTH = 32;
    localparam int DEF_MUL_LAT    = 2;

    // Width of the limit constants returned below; the PE truncates them to
    // its own PSUM_WIDTH, so any PSUM_WIDTH up to this value is supported.
    localparam int PSUM_LIMIT_W = 128;

    // Largest signed value representable in 'width' bits: 0111...1
    function automatic logic [PSUM_LIMIT_W-1:0] psum_max(input int unsigned width);
        return (PSUM_LIMIT_W'(1) << (width - 1)) - PSUM_LIMIT_W'(1);
    endfunction

    // Smallest signed value in 'width' bits: 1000...0 in the low 'width' bits.
    function automatic logic [PSUM_LIMIT_W-1:0] psum_min(input int unsigned width);
        return PSUM_LIMIT_W'(1) << (width - 1);
    endfunction

    // Signed add overflow: both operands share a sign, the result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : systolic_pe_v2_pkg

// File: rtl/systolic_pe_v2_mul_pipe.sv
// -----------------------------------------------------------------------------
// systolic_mul_pipe
//
// Purpose: signed DATA_WIDTH x DATA_WIDTH multiplier with MUL_LAT register
// stages and a matching valid shift chain. The product of an operand pair
// presented with issue_i=1 appears on prod_o with prod_valid_o=1 exactly
// MUL_LAT cycles later. One issue per cycle is accepted (no backpressure).
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset (valid chain only)
//   issue_i       in   operands a_i/b_i are valid this cycle
//   a_i, b_i      in   signed operands, DATA_WIDTH bits
//   prod_valid_o  out  prod_o carries a product issued MUL_LAT cycles ago
//   prod_o        out  signed product, 2*DATA_WIDTH bits
// -----------------------------------------------------------------------------
module systolic_mul_pipe
    import systolic_pe_v2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           issue_i,
    input  logic signed [DATA_WIDTH-1:0]   a_i,
    input  logic signed [DATA_WIDTH-1:0]   b_i,
    output logic                           prod_valid_o,
    output logic signed [2*DATA_WIDTH-1:0] prod_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q [MUL_LAT];
    logic [MUL_LAT-1:0]   vld_q;

    // Operands are widened before the multiply so the full signed product
    // (including -2^(W-1) * -2^(W-1)) is formed without truncation.
    always_comb begin
        prod_d = PW'(a_i) * PW'(b_i);
    end

    // Valid chain: the only state that must be cleared by reset, so a reset
    // discards every in-flight product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Product data stages are qualified by the valid chain and need no reset.
    always_ff @(posedge clk_i) begin
        prod_q[0] <= prod_d;
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign prod_valid_o = vld_q[MUL_LAT-1];
    assign prod_o       = prod_q[MUL_LAT-1];

endmodule : systolic_mul_pipe

// File: rtl/systolic_pe_v2.sv
// -----------------------------------------------------------------------------
// systolic_pe_v2
//
// Purpose: one cell of a weight-stationary systolic array computing
//   out_psum = in_psum + in_data * active_weight
// with double-buffered weights (shadow loads while active streams, explicit
// swap), a MUL_LAT-deep multiplier, psum valid tracking, 1-cycle forwarding of
// A data (rightwards) and weights (downwards), and a sticky overflow flag.
//
// Handshake: valid-only, no backpressure. A *valid signal high means its
// companion data is meaningful in that same cycle and is consumed on that
// clock edge; forwarded data registers hold their value while valid is low.
//
// Timing: issue at cycle t (in_data_valid=1) -> product valid at t+MUL_LAT,
// where in_psum_data is sampled (0 if in_psum_valid=0) -> out_psum_valid and
// out_psum_data at t+MUL_LAT+1.
//
// Ports:
//   s_clk, s_rst_n                      clock, asynchronous active-low reset
//   weight_valid, weights               load shadow weight
//   weight_swap                         copy shadow into active
//   out_weight_valid, out_weights       weight path forwarded to PE below
//   in_data_valid, in_raw_data          A operand (issue)
//   out_data_valid, out_raw_data        A path forwarded to PE on the right
//   in_psum_valid, in_psum_data         psum from PE above
//   out_psum_valid, out_psum_data       accumulated psum
//   psum_ovf                            sticky signed-add overflow flag
//
// Configuration macro: SYSTOLIC_PE_SAT_EN -- when defined an overflowing sum
// clamps to the signed max/min; otherwise it wraps. psum_ovf works either way.
// PSUM_WIDTH must be >= 2*DATA_WIDTH; MUL_LAT must be >= 1.
// -----------------------------------------------------------------------------
module systolic_pe_v2
    import systolic_pe_v2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    // weight path
    input  logic                  weight_valid,
    input  logic [DATA_WIDTH-1:0] weights,
    input  logic                  weight_swap,
    output logic                  out_weight_valid,
    output logic [DATA_WIDTH-1:0] out_weights,
    // A data path
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_raw_data,
    output logic                  out_data_valid,
    output logic [DATA_WIDTH-1:0] out_raw_data,
    // psum path
    input  logic                  in_psum_valid,
    input  logic [PSUM_WIDTH-1:0] in_psum_data,
    output logic                  out_psum_valid,
    output logic [PSUM_WIDTH-1:0] out_psum_data,
    output logic                  psum_ovf
);

    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = PSUM_WIDTH'(psum_max(PSUM_WIDTH));
    localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = PSUM_WIDTH'(psum_min(PSUM_WIDTH));

    // ---------------------------------------------------------------- state
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  out_weight_valid_q, out_weight_valid_d;
    logic [DATA_WIDTH-1:0] out_weights_q, out_weights_d;
    logic                  out_data_valid_q, out_data_valid_d;
    logic [DATA_WIDTH-1:0] out_raw_data_q, out_raw_data_d;
    logic                  out_psum_valid_q, out_psum_valid_d;
    logic [PSUM_WIDTH-1:0] out_psum_data_q, out_psum_data_d;
    logic                  psum_ovf_q, psum_ovf_d;

    // ---------------------------------------------------------- multiplier
    logic                           prod_valid;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [PSUM_WIDTH-1:0]   prod_ext;

    systolic_mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_LAT    (MUL_LAT)
    ) u_mul (
        .clk_i        (s_clk),
        .rst_ni       (s_rst_n),
        .issue_i      (in_data_valid),
        .a_i          (in_raw_data),
        .b_i          (active_q),
        .prod_valid_o (prod_valid),
        .prod_o       (prod)
    );

    // Size cast of a signed value sign-extends the product to psum width.
    assign prod_ext = PSUM_WIDTH'(prod);

    // ---------------------------------------------------------- accumulate
    logic [PSUM_WIDTH-1:0] addend;
    logic [PSUM_WIDTH-1:0] sum_wrap;
    logic [PSUM_WIDTH-1:0] sum_res;
    logic                  sum_ovf;

    always_comb begin
        addend   = in_psum_valid ? in_psum_data : '0;
        sum_wrap = prod_ext + addend;
        sum_ovf  = add_ovf(prod_ext[PSUM_WIDTH-1], addend[PSUM_WIDTH-1],
                           sum_wrap[PSUM_WIDTH-1]);
`ifdef SYSTOLIC_PE_SAT_EN
        // On overflow both operands share a sign; that sign picks the rail.
        if (sum_ovf) begin
            sum_res = prod_ext[PSUM_WIDTH-1] ? PSUM_MIN : PSUM_MAX;
        end else begin
            sum_res = sum_wrap;
        end
`else
        sum_res = sum_wrap;
`endif
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        shadow_d           = shadow_q;
        active_d           = active_q;
        out_weight_valid_d = weight_valid;
        out_weights_d      = out_weights_q;
        out_data_valid_d   = in_data_valid;
        out_raw_data_d     = out_raw_data_q;
        out_psum_valid_d   = prod_valid;
        out_psum_data_d    = out_psum_data_q;
        psum_ovf_d         = psum_ovf_q;

        // Swap reads shadow_q, so a simultaneous load puts the OLD shadow in
        // active while the new weight lands in shadow.
        if (weight_swap) begin
            active_d = shadow_q;
        end
        if (weight_valid) begin
            shadow_d      = weights;
            out_weights_d = weights;
        end
        if (in_data_valid) begin
            out_raw_data_d = in_raw_data;
        end
        // in_psum_valid without a product is ignored.
        if (prod_valid) begin
            out_psum_data_d = sum_res;
            psum_ovf_d      = psum_ovf_q | sum_ovf;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            shadow_q           <= '0;
            active_q           <= '0;
            out_weight_valid_q <= 1'b0;
            out_weights_q      <= '0;
            out_data_valid_q   <= 1'b0;
            out_raw_data_q     <= '0;
            out_psum_valid_q   <= 1'b0;
            out_psum_data_q    <= '0;
            psum_ovf_q         <= 1'b0;
        end else begin
            shadow_q           <= shadow_d;
            active_q           <= active_d;
            out_weight_valid_q <= out_weight_valid_d;
            out_weights_q      <= out_weights_d;
            out_data_valid_q   <= out_data_valid_d;
            out_raw_data_q     <= out_raw_data_d;
            out_psum_valid_q   <= out_psum_valid_d;
            out_psum_data_q    <= out_psum_data_d;
            psum_ovf_q         <= psum_ovf_d;
        end
    end

    assign out_weight_valid = out_weight_valid_q;
    assign out_weights      = out_weights_q;
    assign out_data_valid   = out_data_valid_q;
    assign out_raw_data     = out_raw_data_q;
    assign out_psum_valid   = out_psum_valid_q;
    assign out_psum_data    = out_psum_data_q;
    assign psum_ovf         = psum_ovf_q;

endmodule : systolic_pe_v2

// File: tb/tb_systolic_pe_v2.sv
// Directed bench for systolic_pe_v2. Two instances share all inputs:
// dut_a (PSUM_WIDTH=32) and dut_b (PSUM_WIDTH=16, exercises overflow).
module tb_systolic_pe_v2;

  // -------------------------------------------------- clock / reset
  logic s_clk   = 1'b0;
  logic s_rst_n = 1'b1;
  always #5 s_clk = ~s_clk;

  // -------------------------------------------------- stimulus
  logic        weight_valid  = 1'b0;
  logic [7:0]  weights       = '0;
  logic        weight_swap   = 1'b0;
  logic        in_data_valid = 1'b0;
  logic [7:0]  in_raw_data   = '0;
  logic        in_psum_valid = 1'b0;
  logic [31:0] in_psum_data  = '0;

  // -------------------------------------------------- observed
  logic        a_owv, a_dv, a_pv, a_ovf;
  logic [7:0]  a_ow, a_raw;
  logic [31:0] a_psum;
  logic        b_owv, b_dv, b_pv, b_ovf;
  logic [7:0]  b_ow, b_raw;
  logic [15:0] b_psum;

  systolic_pe_v2 #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .MUL_LAT(2)) dut_a (
    .s_clk(s_clk), .s_rst_n(s_rst_n),
    .weight_valid(weight_valid), .weights(weights), .weight_swap(weight_swap),
    .out_weight_valid(a_owv), .out_weights(a_ow),
    .in_data_valid(in_data_valid), .in_raw_data(in_raw_data),
    .out_data_valid(a_dv), .out_raw_data(a_raw),
    .in_psum_valid(in_psum_valid), .in_psum_data(in_psum_data),
    .out_psum_valid(a_pv), .out_psum_data(a_psum), .psum_ovf(a_ovf)
  );

  systolic_pe_v2 #(.DATA_WIDTH(8), .PSUM_WIDTH(16), .MUL_LAT(2)) dut_b (
    .s_clk(s_clk), .s_rst_n(s_rst_n),
    .weight_valid(weight_valid), .weights(weights), .weight_swap(weight_swap),
    .out_weight_valid(b_owv), .out_weights(b_ow),
    .in_data_valid(in_data_valid), .in_raw_data(in_raw_data),
    .out_data_valid(b_dv), .out_raw_data(b_raw),
    .in_psum_valid(in_psum_valid), .in_psum_data(in_psum_data[15:0]),
    .out_psum_valid(b_pv), .out_psum_data(b_psum), .psum_ovf(b_ovf)
  );

  // -------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_owv"},  32'(a_owv),  32'd0);
    chk({tag, "_a_ow"},   32'(a_ow),   32'd0);
    chk({tag, "_a_dv"},   32'(a_dv),   32'd0);
    chk({tag, "_a_raw"},  32'(a_raw),  32'd0);
    chk({tag, "_a_pv"},   32'(a_pv),   32'd0);
    chk({tag, "_a_psum"}, a_psum,      32'd0);
    chk({tag, "_a_ovf"},  32'(a_ovf),  32'd0);
    chk({tag, "_b_pv"},   32'(b_pv),   32'd0);
    chk({tag, "_b_psum"}, 32'(b_psum), 32'd0);
    chk({tag, "_b_ovf"},  32'(b_ovf),  32'd0);
  endtask

  // -------------------------------------------------- driver tasks
  // Inputs change 1 time unit after the rising edge; outputs read then
  // reflect the edge that just happened.
  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic idle();
    weight_valid  = 1'b0;
    weight_swap   = 1'b0;
    in_data_valid = 1'b0;
    in_psum_valid = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] w);
    weight_valid = 1'b1;
    weights      = w;
    step();
    weight_valid = 1'b0;
  endtask

  task automatic swap_w();
    weight_swap = 1'b1;
    step();
    weight_swap = 1'b0;
  endtask

  // Issue d at t, supply psum at t+2, expect the result at t+3 exactly.
  task automatic mac_one(input string tag, input logic [7:0] d, input logic pv,
                         input logic [31:0] ps, input logic [31:0] exp_a,
                         input logic [15:0] exp_b);
    in_data_valid = 1'b1;
    in_raw_data   = d;
    step();                                   // t+1
    in_data_valid = 1'b0;
    chk({tag, "_dv"},  32'(a_dv),  32'd1);
    chk({tag, "_raw"}, 32'(a_raw), 32'(d));
    step();                                   // t+2
    chk({tag, "_pv_early"}, 32'(a_pv), 32'd0);
    in_psum_valid = pv;
    in_psum_data  = ps;
    step();                                   // t+3
    in_psum_valid = 1'b0;
    chk({tag, "_a_pv"},   32'(a_pv),   32'd1);
    chk({tag, "_a_psum"}, a_psum,      exp_a);
    chk({tag, "_b_pv"},   32'(b_pv),   32'd1);
    chk({tag, "_b_psum"}, 32'(b_psum), 32'(exp_b));
  endtask

  // -------------------------------------------------- directed sequence
  initial begin
    // 1. reset held with toggling inputs, then released
    #1 s_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      weight_valid  = 1'($urandom_range(0, 1));
      weights       = 8'($urandom_range(0, 255));
      weight_swap   = 1'($urandom_range(0, 1));
      in_data_valid = 1'($urandom_range(0, 1));
      in_raw_data   = 8'($urandom_range(0, 255));
      in_psum_valid = 1'($urandom_range(0, 1));
      in_psum_data  = $urandom;
      step();
      chk_zero("rst_hold");
    end
    idle();
    in_psum_data = '0;
    s_rst_n = 1'b1;
    step();
    step();
    chk_zero("rst_release");

    // 2. basic MAC: 3*5 + 10 = 25
    load_w(8'd3);
    chk("fwd_wv",  32'(a_owv), 32'd1);
    chk("fwd_w",   32'(a_ow),  32'd3);
    swap_w();
    chk("fwd_wv_low", 32'(a_owv), 32'd0);
    mac_one("basic", 8'd5, 1'b1, 32'd10, 32'd25, 16'd25);
    chk("fwd_w_hold", 32'(a_ow), 32'd3);
    step();
    chk("basic_pv_drop",  32'(a_pv), 32'd0);
    chk("basic_psum_hold", a_psum,   32'd25);
    chk("basic_raw_hold", 32'(a_raw), 32'd5);

    // 3. signed / top row
    load_w(8'h80);
    swap_w();
    mac_one("neg_sq", 8'h80, 1'b0, 32'hDEAD_BEEF, 32'd16384, 16'd16384);
    load_w(8'hFF);
    swap_w();
    mac_one("neg_one", 8'd127, 1'b1, 32'd0, 32'hFFFF_FF81, 16'hFF81);
    chk("no_ovf_yet", 32'(b_ovf), 32'd0);

    // 4. double buffer: active 2, shadow 7, swap with 3rd issue
    load_w(8'd2);
    swap_w();
    load_w(8'd7);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd7);
    for (int c = 0; c < 6; c++) begin
      in_data_valid = (c < 4);
      in_raw_data   = 8'd1;
      weight_swap   = (c == 2);
      weight_valid  = (c == 2);
      weights       = 8'd9;
      step();
      if (c >= 2) begin
        chk("dbuf_pv", 32'(a_pv), 32'd1);
        if (exp_q.size() == 0) begin
          chk("dbuf_q_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("dbuf_psum", a_psum, exp_q.pop_front());
        end
      end
    end
    idle();
    step();
    chk("dbuf_pv_end",   32'(a_pv), 32'd0);
    chk("dbuf_psum_hold", a_psum,   32'd7);
    chk("dbuf_fwd_w",    32'(a_ow), 32'd9);
    swap_w();
    mac_one("dbuf_new_shadow", 8'd2, 1'b1, 32'd1, 32'd19, 16'd19);

    // 5. overflow on the 16-bit instance
    load_w(8'd1);
    swap_w();
`ifdef SYSTOLIC_PE_SAT_EN
    mac_one("ovf_pos", 8'd1, 1'b1, 32'd32767, 32'd32768, 16'h7FFF);
`else
    mac_one("ovf_pos", 8'd1, 1'b1, 32'd32767, 32'd32768, 16'h8000);
`endif
    chk("ovf_pos_b_flag", 32'(b_ovf), 32'd1);
    chk("ovf_pos_a_flag", 32'(a_ovf), 32'd0);
    mac_one("ovf_sticky", 8'd0, 1'b1, 32'd5, 32'd5, 16'd5);
    chk("ovf_sticky_flag", 32'(b_ovf), 32'd1);
`ifdef SYSTOLIC_PE_SAT_EN
    mac_one("ovf_neg", 8'hFF, 1'b1, 32'hFFFF_8000, 32'hFFFF_7FFF, 16'h8000);
`else
    mac_one("ovf_neg", 8'hFF, 1'b1, 32'hFFFF_8000, 32'hFFFF_7FFF, 16'h7FFF);
`endif
    chk("ovf_neg_b_flag", 32'(b_ovf), 32'd1);
    chk("ovf_neg_a_flag", 32'(a_ovf), 32'd0);

    // 6. reset mid-stream discards in-flight products
    in_data_valid = 1'b1;
    in_raw_data   = 8'd1;
    step();
    in_raw_data   = 8'd2;
    step();
    in_raw_data   = 8'd3;
    step();
    idle();
    s_rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_async");
    #2;
    s_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_pv_a", 32'(a_pv), 32'd0);
      chk("rst_mid_no_pv_b", 32'(b_pv), 32'd0);
    end
    chk("rst_mid_ovf_clr", 32'(b_ovf), 32'd0);
    // active weight was cleared, so only the psum passes through
    mac_one("rst_active_zero", 8'd5, 1'b1, 32'd10, 32'd10, 16'd10);
    load_w(8'd3);
    swap_w();
    mac_one("post_rst", 8'd5, 1'b1, 32'd10, 32'd25, 16'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_systolic_pe_v2
